// File: rtl/serial_io_if.sv
// CPU-side bus bundle for serial_io: address, DI/DO strobes and the shared
// 16-bit tri-state data bus.
// The device and the CPU each get a value/enable pair. The bus net itself
// is resolved here, so both sides see one wire.
interface serial_io_if;
  logic [15:0] addr;
  logic        DI;
  logic        DO;
  wire  [15:0] bus;

  // device-side driver: enabled only during a decoded read
  logic [15:0] dev_dout;
  logic        dev_oe;
  // CPU-side driver: enabled while the CPU presents write data
  logic [15:0] cpu_dout;
  logic        cpu_oe;

  assign bus = dev_oe ? dev_dout : 16'hzzzz;
  assign bus = cpu_oe ? cpu_dout : 16'hzzzz;

  modport slave  (input addr, DI, DO, bus, output dev_dout, dev_oe);
  modport master (output addr, DI, DO, cpu_dout, cpu_oe, input bus);
endinterface

// File: rtl/serial_io.sv
// serial_io: UART-style 8N1 peripheral on the CPU DI/DO bus.
// Data register at BASE, status register at BASE+1. DIV is clk cycles per bit.
// Writing to BASE sends a byte on txd. Bytes received on rxd are held for the CPU.
// Status = {9'b0, rx_level[2:0], ferr, ovr, tx_busy, rx_valid}.
// Build option: define SERIAL_IO_RXFIFO_EN to replace the single RX holding
// register with a 4-entry FIFO. rx_level then reports the FIFO occupancy.
module serial_io #(
  parameter logic [15:0] BASE = 16'h0080,
  parameter int          DIV  = 16
) (
  input  logic       clk,
  input  logic       RST_bar,
  serial_io_if.slave cpu,
  output logic       txd,
  input  logic       rxd
);
  localparam int            CW     = $clog2(DIV);
  localparam logic [CW-1:0] C_BIT  = CW'(DIV - 1);
  localparam logic [CW-1:0] C_HALF = CW'(DIV / 2 - 1);
  localparam logic [15:0]   STAT_A = BASE + 16'd1;

  // ---------------- address decode ----------------
  // DI has priority: a cycle with both strobes high is treated as a read.
  logic rd_data, rd_stat, wr_data;
  assign rd_data = cpu.DI && (cpu.addr == BASE);
  assign rd_stat = cpu.DI && (cpu.addr == STAT_A);
  assign wr_data = cpu.DO && !cpu.DI && (cpu.addr == BASE);

  // ---------------- transmitter ----------------
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_st_e;
  tx_st_e        tx_st_q, tx_st_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_sh_q, tx_sh_d;
  logic          txd_q, txd_d;
  logic          tx_busy, tx_bit_end, tx_acc;

  assign tx_busy    = (tx_st_q != TX_IDLE);
  assign tx_bit_end = (tx_cnt_q == C_BIT);
  // The last cycle of the stop bit can accept the next byte, so frames can run back to back.
  assign tx_acc     = wr_data && (!tx_busy || (tx_st_q == TX_STOP && tx_bit_end));
  assign txd        = txd_q;

  // TX state register; reset forces the line idle-high immediately
  always_ff @(posedge clk or negedge RST_bar) begin
    if (!RST_bar) begin
      tx_st_q  <= TX_IDLE;
      tx_cnt_q <= '0;
      tx_bit_q <= '0;
      tx_sh_q  <= '0;
      txd_q    <= 1'b1;
    end else begin
      tx_st_q  <= tx_st_d;
      tx_cnt_q <= tx_cnt_d;
      tx_bit_q <= tx_bit_d;
      tx_sh_q  <= tx_sh_d;
      txd_q    <= txd_d;
    end
  end

  // TX next state: start bit on acceptance, LSB-first data, stop bit
  always_comb begin
    tx_st_d  = tx_st_q;
    tx_cnt_d = tx_cnt_q;
    tx_bit_d = tx_bit_q;
    tx_sh_d  = tx_sh_q;
    txd_d    = txd_q;
    if (tx_acc) begin
      tx_st_d  = TX_START;
      tx_cnt_d = '0;
      tx_sh_d  = cpu.bus[7:0];
      txd_d    = 1'b0;
    end else if (tx_busy) begin
      tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + 1'b1;
      if (tx_bit_end) begin
        case (tx_st_q)
          TX_START: begin
            tx_st_d  = TX_DATA;
            tx_bit_d = '0;
            txd_d    = tx_sh_q[0];
          end
          TX_DATA: begin
            if (tx_bit_q == 3'd7) begin
              tx_st_d = TX_STOP;
              txd_d   = 1'b1;
            end else begin
              tx_bit_d = tx_bit_q + 1'b1;
              tx_sh_d  = {1'b0, tx_sh_q[7:1]};
              txd_d    = tx_sh_q[1];
            end
          end
          TX_STOP: begin
            tx_st_d = TX_IDLE;
            txd_d   = 1'b1;
          end
          default: tx_st_d = TX_IDLE;
        endcase
      end
    end
  end

  // ---------------- receiver ----------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_st_e;
  rx_st_e        rx_st_q, rx_st_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic          rx_s1_q, rx_s2_q;
  logic          rx_ok, rx_bad, rx_bit_end;

  assign rx_bit_end = (rx_cnt_q == C_BIT);

  // rxd is asynchronous to clk: two-flop synchronizer, reset to the idle-high level
  always_ff @(posedge clk or negedge RST_bar) begin
    if (!RST_bar) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
    end else begin
      rx_s1_q <= rxd;
      rx_s2_q <= rx_s1_q;
    end
  end

  // RX state register; reset drops any partial byte
  always_ff @(posedge clk or negedge RST_bar) begin
    if (!RST_bar) begin
      rx_st_q  <= RX_IDLE;
      rx_cnt_q <= '0;
      rx_bit_q <= '0;
      rx_sh_q  <= '0;
    end else begin
      rx_st_q  <= rx_st_d;
      rx_cnt_q <= rx_cnt_d;
      rx_bit_q <= rx_bit_d;
      rx_sh_q  <= rx_sh_d;
    end
  end

  // RX next state: confirm the start bit at half a bit, then sample mid-bit
  always_comb begin
    rx_st_d  = rx_st_q;
    rx_cnt_d = rx_cnt_q;
    rx_bit_d = rx_bit_q;
    rx_sh_d  = rx_sh_q;
    rx_ok    = 1'b0;
    rx_bad   = 1'b0;
    case (rx_st_q)
      RX_IDLE: begin
        if (!rx_s2_q) begin
          rx_st_d  = RX_START;
          rx_cnt_d = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == C_HALF) begin
          rx_cnt_d = '0;
          rx_bit_d = '0;
          rx_st_d  = rx_s2_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_bit_end) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
          if (rx_bit_q == 3'd7) rx_st_d  = RX_STOP;
          else                  rx_bit_d = rx_bit_q + 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_bit_end) begin
          rx_cnt_d = '0;
          rx_st_d  = RX_IDLE;
          rx_ok    = rx_s2_q;
          rx_bad   = !rx_s2_q;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_st_d = RX_IDLE;
    endcase
  end

  // ---------------- receive storage ----------------
  logic       rx_valid, ovr_set;
  logic [7:0] rd_byte;
  logic [2:0] rx_lvl;

`ifdef SERIAL_IO_RXFIFO_EN
  logic [3:0][7:0] fifo_q, fifo_d;
  logic [1:0]      rp_q, rp_d, wp_q, wp_d;
  logic [2:0]      lvl_q, lvl_d;
  logic            pop, push;

  // A pop and a push in the same cycle when full both succeed.
  assign pop      = rd_data && (lvl_q != 3'd0);
  assign push     = rx_ok && ((lvl_q != 3'd4) || pop);
  assign ovr_set  = rx_ok && !push;
  assign rx_valid = (lvl_q != 3'd0);
  assign rd_byte  = fifo_q[rp_q];
  assign rx_lvl   = lvl_q;

  // FIFO next state: pointers and occupancy
  always_comb begin
    fifo_d = fifo_q;
    rp_d   = rp_q + {1'b0, pop};
    wp_d   = wp_q + {1'b0, push};
    lvl_d  = lvl_q + {2'b0, push} - {2'b0, pop};
    if (push) fifo_d[wp_q] = rx_sh_q;
  end

  // FIFO storage register
  always_ff @(posedge clk or negedge RST_bar) begin
    if (!RST_bar) begin
      fifo_q <= '0;
      rp_q   <= '0;
      wp_q   <= '0;
      lvl_q  <= '0;
    end else begin
      fifo_q <= fifo_d;
      rp_q   <= rp_d;
      wp_q   <= wp_d;
      lvl_q  <= lvl_d;
    end
  end
`else
  logic [7:0] hold_q, hold_d;
  logic       hold_v_q, hold_v_d;

  assign rx_valid = hold_v_q;
  assign rd_byte  = hold_q;
  assign rx_lvl   = 3'd0;

  // Holding register: a read clears it first, so a byte finishing in that same cycle still loads.
  always_comb begin
    hold_d   = hold_q;
    hold_v_d = hold_v_q && !rd_data;
    ovr_set  = 1'b0;
    if (rx_ok) begin
      if (hold_v_d) begin
        ovr_set = 1'b1;
      end else begin
        hold_d   = rx_sh_q;
        hold_v_d = 1'b1;
      end
    end
  end

  // holding register storage
  always_ff @(posedge clk or negedge RST_bar) begin
    if (!RST_bar) begin
      hold_q   <= '0;
      hold_v_q <= 1'b0;
    end else begin
      hold_q   <= hold_d;
      hold_v_q <= hold_v_d;
    end
  end
`endif

  // ---------------- sticky flags ----------------
  logic ferr_q, ferr_d, ovr_q, ovr_d;

  // A status read clears the flags, but a new set in the same cycle wins.
  always_comb begin
    ferr_d = rx_bad  | (ferr_q & !rd_stat);
    ovr_d  = ovr_set | (ovr_q  & !rd_stat);
  end

  // flag registers
  always_ff @(posedge clk or negedge RST_bar) begin
    if (!RST_bar) begin
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      ferr_q <= ferr_d;
      ovr_q  <= ovr_d;
    end
  end

  // ---------------- bus read-back ----------------
  logic [15:0] status;
  assign status       = {9'h000, rx_lvl, ferr_q, ovr_q, tx_busy, rx_valid};
  assign cpu.dev_oe   = rd_data || rd_stat;
  assign cpu.dev_dout = rd_data ? (rx_valid ? {8'h00, rd_byte} : 16'h0000) :
                        rd_stat ? status : 16'h0000;
endmodule

// File: tb/tb_serial_io.sv
// Self-checking bench for serial_io (DIV=4).
// TX waveforms and RX bus reads are compared against a byte-queue model
// of the receive storage.
`timescale 1ns/1ps
module tb_serial_io;
  localparam int          DIV  = 4;
  localparam logic [15:0] BASE = 16'h0080;
  localparam logic [15:0] STAT = 16'h0081;
  // cycle index, counted from the first negedge of a frame, at which a read
  // lands on the same edge as the mid-stop sample
  localparam int          C_DONE = 2 + DIV / 2 + 9 * DIV;
`ifdef SERIAL_IO_RXFIFO_EN
  localparam int CAP = 4;
  localparam bit FIFO = 1'b1;
`else
  localparam int CAP = 1;
  localparam bit FIFO = 1'b0;
`endif

  logic clk = 1'b0;
  logic RST_bar = 1'b0;
  logic rxd = 1'b1;
  logic txd;

  serial_io_if sif();
  serial_io #(.BASE(BASE), .DIV(DIV)) dut (
    .clk(clk), .RST_bar(RST_bar), .cpu(sif.slave), .txd(txd), .rxd(rxd));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // receive model: bytes held for the CPU, plus sticky flags
  logic [7:0] rxq[$];
  logic       m_ferr = 1'b0;
  logic       m_ovr  = 1'b0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int k);
    int bi;
    bi = k / DIV;
    if (bi == 0) return 1'b0;
    if (bi <= 8) return b[bi-1];
    return 1'b1;
  endfunction

  function automatic logic [15:0] m_stat();
    logic [2:0] lvl;
    lvl = FIFO ? 3'(rxq.size()) : 3'd0;
    return {9'h000, lvl, m_ferr, m_ovr, 1'b0, rxq.size() != 0};
  endfunction

  function automatic logic [15:0] m_pop();
    if (rxq.size() == 0) return 16'h0000;
    return {8'h00, rxq.pop_front()};
  endfunction

  // All bus tasks start and end on a negedge.
  task automatic rd(input logic [15:0] a, output logic [15:0] d);
    sif.addr = a; sif.DI = 1'b1;
    #1 d = sif.bus;
    @(negedge clk);
    sif.DI = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    sif.addr = a; sif.cpu_dout = d; sif.cpu_oe = 1'b1; sif.DO = 1'b1;
    @(negedge clk);
    sif.DO = 1'b0; sif.cpu_oe = 1'b0;
  endtask

  task automatic rd_stat_chk(input string tag);
    logic [15:0] d, e;
    e = m_stat();
    rd(STAT, d);
    chk(tag, d, e);
    m_ferr = 1'b0; m_ovr = 1'b0;
  endtask

  task automatic rd_data_chk(input string tag);
    logic [15:0] d, e;
    e = m_pop();
    rd(BASE, d);
    chk(tag, d, e);
  endtask

  // Send byte b and sample txd every cycle. At cycle inj_k, attempt a write of b2.
  // If inj_k is the last stop-bit cycle, b2 must follow back to back.
  // Otherwise it lands mid-frame and must be dropped.
  task automatic tx_run(input string tag, input logic [7:0] b, input int inj_k, input logic [7:0] b2);
    logic e;
    wr(BASE, {8'($urandom), b});
    for (int k = 0; k < 21 * DIV; k++) begin
      if (k < 10 * DIV || inj_k != 10 * DIV - 1) e = frame_bit(b, k);
      else                                      e = frame_bit(b2, k - 10 * DIV);
      chk(tag, 16'(txd), 16'(e));
      if (k == inj_k) begin
        sif.addr = BASE; sif.cpu_dout = {8'h00, b2}; sif.cpu_oe = 1'b1; sif.DO = 1'b1;
      end else begin
        sif.DO = 1'b0; sif.cpu_oe = 1'b0;
      end
      @(negedge clk);
    end
    sif.DO = 1'b0; sif.cpu_oe = 1'b0;
  endtask

  // Drive one 8N1 frame on rxd, then idle high. Optionally read rd_a at cycle rd_at.
  task automatic rx_frame(input logic [7:0] b, input logic stop, input int rd_at,
                          input logic [15:0] rd_a);
    logic [15:0] d, e;
    int bi;
    for (int k = 0; k < 13 * DIV; k++) begin
      bi = k / DIV;
      rxd = (bi == 0) ? 1'b0 : (bi <= 8) ? b[bi-1] : (bi == 9) ? stop : 1'b1;
      if (k == rd_at) begin
        if (rd_a == BASE) e = m_pop();
        else begin e = m_stat(); m_ferr = 1'b0; m_ovr = 1'b0; end
        sif.addr = rd_a; sif.DI = 1'b1;
        #1 d = sif.bus;
        chk("rx_rd_at_done", d, e);
      end else begin
        sif.DI = 1'b0;
      end
      @(negedge clk);
    end
    sif.DI = 1'b0;
    if (!stop)                 m_ferr = 1'b1;
    else if (rxq.size() < CAP) rxq.push_back(b);
    else                       m_ovr = 1'b1;
  endtask

  initial begin
    logic [15:0] d;
    int busy_n;
    logic [7:0] rb;
    sif.addr = '0; sif.DI = 1'b0; sif.DO = 1'b0; sif.cpu_dout = '0; sif.cpu_oe = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_txd", 16'(txd), 16'h0001);
    chk("rst_oe", 16'(sif.dev_oe), 16'h0000);
    RST_bar = 1'b1;
    @(negedge clk);
    rd_stat_chk("stat_empty");
    sif.addr = 16'h0082; sif.DI = 1'b1;
    #1 chk("undecoded_oe", 16'(sif.dev_oe), 16'h0000);
    sif.DI = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_txd", 16'(txd), 16'h0001);
      chk("idle_oe", 16'(sif.dev_oe), 16'h0000);
    end

    // TX 0x12A5 with the status register watched: busy for exactly 10*DIV cycles
    wr(BASE, 16'h12A5);
    sif.addr = STAT; sif.DI = 1'b1;
    busy_n = 0;
    for (int k = 0; k < 12 * DIV; k++) begin
      #1;
      if (sif.bus[1]) busy_n++;
      chk("tx_a5_wave", 16'(txd), 16'(frame_bit(8'hA5, k)));
      @(negedge clk);
    end
    sif.DI = 1'b0;
    chk("tx_busy_len", 16'(busy_n), 16'(10 * DIV));

    // write at cycle 20 is dropped; back-to-back write in last stop cycle is accepted
    tx_run("tx_drop", 8'(8'h3C ^ $urandom), 20, 8'hFF);
    tx_run("tx_b2b", 8'($urandom), 10 * DIV - 1, 8'($urandom));
    repeat (DIV) @(negedge clk);

    // RX single byte
    rx_frame(8'h3C, 1'b1, -1, BASE);
    rd_stat_chk("rx_stat_valid");
    rd_data_chk("rx_data_3c");
    rd_stat_chk("rx_stat_after");

    // two bytes without a read: overrun (or two FIFO entries)
    rx_frame(8'h11, 1'b1, -1, BASE);
    rx_frame(8'h22, 1'b1, -1, BASE);
    rd_stat_chk("ovr_stat");
    rd_data_chk("ovr_data1");
    rd_stat_chk("ovr_stat2");
    rd_data_chk("ovr_data2");
    rd_stat_chk("ovr_stat3");

    // data read on the same edge a byte completes: clear then load
    rx_frame(8'h44, 1'b1, -1, BASE);
    rx_frame(8'h55, 1'b1, C_DONE, BASE);
    rd_stat_chk("sim_rd_stat");
    rd_data_chk("sim_rd_data");

    // framing error, and a status read on the same edge it is set: set wins
    rx_frame(8'hC3, 1'b0, -1, BASE);
    rd_stat_chk("ferr_stat");
    rd_stat_chk("ferr_clr");
    rx_frame(8'h5A, 1'b0, C_DONE, STAT);
    rd_stat_chk("ferr_set_wins");

    // one-cycle low glitch is a false start
    rxd = 1'b0;
    @(negedge clk);
    rxd = 1'b1;
    repeat (3 * DIV) @(negedge clk);
    rd_stat_chk("false_start");
    rd_data_chk("false_start_data");

    // random mix of frames and reads against the model
    for (int i = 0; i < 16; i++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: rx_frame(8'($urandom), 1'b1, -1, BASE);
        3:       rx_frame(8'($urandom), 1'b0, -1, BASE);
        4:       rd_data_chk("rand_data");
        default: rd_stat_chk("rand_stat");
      endcase
    end
    for (int i = 0; i < CAP + 1; i++) begin
      rd_stat_chk("drain_stat");
      rd_data_chk("drain_data");
    end

    // reset during TX data bit 4 of 0xA5 (a 0 bit): txd must go high at once
    wr(BASE, 16'h00A5);
    repeat (5 * DIV) @(negedge clk);
    chk("pre_rst_txd", 16'(txd), 16'h0000);
    #2 RST_bar = 1'b0;
    #1 chk("mid_rst_txd", 16'(txd), 16'h0001);
    rxq.delete(); m_ferr = 1'b0; m_ovr = 1'b0;
    sif.addr = STAT; sif.DI = 1'b1;
    #1 chk("mid_rst_stat", sif.bus, 16'h0000);
    sif.DI = 1'b0;
    repeat (2) @(negedge clk);
    RST_bar = 1'b1;
    @(negedge clk);
    rd_stat_chk("post_rst_stat");
    rb = 8'($urandom);
    tx_run("tx_post_rst", rb, 2, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // global watchdog so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/serial_io.md
Name: serial_io

Overview:
- UART-style I/O peripheral that answers the CPU's device strobes (DI = CPU reads from device, DO = CPU writes to device) on the shared 16-bit bus.
- Two decoded addresses: data at BASE, status at BASE+1.
- CPU writes queue an 8N1 serial transmit on txd; bytes received on rxd are held for the CPU to read back.

Parameters:
- BASE, 16'h0080, data register address; status register is at BASE+1.
- DIV, 16, clk cycles per serial bit. Must be ≥4 and even.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- RST_bar  input  1  reset, asynchronous, active-low.
- addr  input  16  CPU address, valid whenever DI or DO is high.
- bus  inout  16  CPU data bus; driven only during a decoded read, otherwise high-Z.
- DI  input  1  CPU input strobe; device drives bus.
- DO  input  1  CPU output strobe; device samples bus at posedge.
- txd  output  1  serial out; idle high.
- rxd  input  1  serial in; asynchronous to clk.

Behaviour:
- Reset (async, RST_bar low):
  - txd=1, tx_busy=0.
  - RX holding register empty, all sticky flags 0.
  - Both FSMs idle; bus high-Z.
- Reads (combinational drive, edge side-effects):
  - DI && addr==BASE: bus={8'h00, rx_byte}, or 16'h0000 if empty. At posedge, the holding register is cleared.
  - DI && addr==BASE+1: bus={12'h000, ferr, ovr, tx_busy, rx_valid}. At posedge, ferr and ovr are cleared.
  - Any other addr, or DI low: bus=Z. DI and DO both high: DO ignored, DI honoured.
- Writes:
  - DO && addr==BASE && !tx_busy: latch bus[7:0] at posedge and set tx_busy. bus[15:8] is ignored.
  - DO to BASE while tx_busy: dropped, no state change.
  - DO to BASE+1: ignored.
- TX FSM (IDLE, START, DATA, STOP):
  - txd goes low on the same posedge that accepts the write.
  - Frame: start bit 0, then 8 data bits LSB first, then stop bit 1. Each bit lasts DIV cycles.
  - tx_busy clears at the end of the stop bit, exactly 10*DIV cycles after acceptance. A write in that same cycle is accepted.
- RX path:
  - rxd passes through a 2-flop synchronizer before the FSM. This adds 2 cycles of latency.
  - FSM states: IDLE, START, DATA, STOP.
  - IDLE → START on synced low.
  - START waits DIV/2 cycles and re-samples. If high: false start, return to IDLE. If low: go to DATA.
  - DATA samples 8 bits at DIV spacing, mid-bit, LSB first.
  - STOP samples at mid-bit, then returns to IDLE at that sample.
  - Stop bit = 0: set ferr, discard byte.
  - Stop bit = 1 and holding register empty: load byte, set rx_valid.
  - Stop bit = 1 and holding register full: set ovr, discard new byte, keep old one.
- Simultaneous events:
  - A data-register read clears the holding register in the same cycle an RX byte completes: the new byte is loaded and rx_valid stays 1. Clear happens first, then load.
  - A status read clears ferr/ovr in the same cycle one of them is set: the flag stays set. Set wins.
- Mid-operation reset:
  - Aborts both frames; txd returns to 1 immediately, asynchronously.
  - A partial RX byte is discarded.

Optional Feature:
- Macro: SERIAL_IO_RXFIFO_EN.
- Defined: the RX holding register becomes a 4-entry FIFO.
  - rx_valid means non-empty. Data reads pop the oldest entry.
  - ovr is set only when a byte completes while 4 entries are held.
  - Status bits [6:4] hold the entry count, 0–4.
  - Simultaneous pop and push when full: both succeed, no ovr.
- Undefined: single holding register as described above; status bits [6:4] read 0.

Test Plan:
- Reset, then DI at BASE+1 with nothing received → bus=16'h0000. Idle cycles → txd=1; bus=Z whenever DI is low.
- DIV=4, DO at BASE with bus=16'h12A5 → txd sequence 0, then 1,0,1,0,0,1,0,1, then 1, each level held 4 cycles. Status bit1 is 1 for exactly 40 cycles. A second write at cycle 20 is dropped: no frame follows.
- DIV=4, drive rxd frame with byte 0x3C → after the mid-stop sample, status=16'h0001. DI at BASE returns 16'h003C; next status read gives 16'h0000.
- Two frames 0x11 then 0x22 with no read in between → data read returns 0x0011 and status shows ovr (bit2). After that status read, bit2 clears. With SERIAL_IO_RXFIFO_EN, both bytes are read in order, ovr stays 0, and status[6:4] steps 2 → 1 → 0.
- rxd low pulse of 1 cycle → false start: no byte and no flags. A frame with stop bit 0 → ferr (bit3) set, rx_valid stays 0.
- Assert RST_bar low mid-TX at bit 4 → txd=1 within the same cycle and tx_busy=0. After release, a new write transmits a clean full frame.
